// File: rtl/vc_latency_sink.sv
// Receive-end sink for a fixed-latency unstallable pipe: credit-gated issue, FIFO capture, val/rdy dequeue.
// Optional macro VC_LATENCY_SINK_BYPASS_EN adds a same-cycle pipe->deq path when the FIFO is empty.
module vc_latency_sink #(
  parameter int DATA_WIDTH = 12,
  parameter int NUM_CYCLES = 1,
  parameter int DEPTH      = NUM_CYCLES + 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         req_val,
  output logic                         req_rdy,
  input  logic                         pipe_val,
  input  logic [DATA_WIDTH-1:0]        pipe_data,
  output logic                         deq_val,
  input  logic                         deq_rdy,
  output logic [DATA_WIDTH-1:0]        deq_data,
  output logic [$clog2(DEPTH+1)-1:0]   credits,
  output logic                         overflow
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (NUM_CYCLES < 1 || DEPTH < 1) begin : g_cfg_check
    $error("vc_latency_sink: NUM_CYCLES and DEPTH must both be >= 1");
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d, credits_q, credits_d;
  logic                  req_rdy_q, overflow_q, overflow_d;
  logic                  empty, full, issue_fire, deq_fire, fifo_rd, wr_en;

  assign empty      = (count_q == '0);
  assign full       = (count_q == CNT_W'(DEPTH));
  assign issue_fire = req_val & req_rdy_q;

`ifdef VC_LATENCY_SINK_BYPASS_EN
  logic pipe_v;
  logic bypass;
  // Pipe data is ignored while held in reset, including on the bypass path.
  assign pipe_v   = pipe_val & reset_n;
  assign bypass   = empty & pipe_v;
  assign deq_val  = ~empty | pipe_v;
  assign deq_data = empty ? pipe_data : mem_q[rd_ptr_q];
  assign deq_fire = deq_val & deq_rdy;
  assign fifo_rd  = deq_fire & ~empty;
  assign wr_en    = pipe_v & (~full | deq_fire) & ~(bypass & deq_rdy);
`else
  assign deq_val  = ~empty;
  assign deq_data = mem_q[rd_ptr_q];
  assign deq_fire = deq_val & deq_rdy;
  assign fifo_rd  = deq_fire;
  assign wr_en    = pipe_val & (~full | deq_fire);
`endif

  always_comb begin
    wr_ptr_d   = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = fifo_rd ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d    = count_q + CNT_W'(wr_en) - CNT_W'(fifo_rd);
    credits_d  = credits_q - CNT_W'(issue_fire) + CNT_W'(deq_fire);
    overflow_d = overflow_q | (pipe_val & full & ~deq_fire);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      credits_q  <= CNT_W'(DEPTH);
      req_rdy_q  <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      credits_q  <= credits_d;
      // Registered ready: no combinational path from req_val.
      req_rdy_q  <= (credits_d != '0);
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && wr_en) mem_q[wr_ptr_q] <= pipe_data;
  end

  assign req_rdy  = req_rdy_q;
  assign credits  = credits_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_vc_latency_sink.sv
// Directed bench for vc_latency_sink (DEPTH=3, NUM_CYCLES=1) with a one-cycle delay-line model.
module tb_vc_latency_sink;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, req_val, req_rdy, pipe_val, deq_val, deq_rdy, overflow;
  logic [11:0] pipe_data, deq_data, req_data;
  logic [1:0]  credits;

  int checks = 0, failures = 0, cyc = 0, occ = 0, n_issued = 0;
  logic [11:0] iss_q[$];
  logic [11:0] log_q[$];
  int          logc_q[$];

`ifdef VC_LATENCY_SINK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  vc_latency_sink #(.DATA_WIDTH(12), .NUM_CYCLES(1), .DEPTH(3)) dut (
    .clk(clk), .reset_n(reset_n), .req_val(req_val), .req_rdy(req_rdy),
    .pipe_val(pipe_val), .pipe_data(pipe_data), .deq_val(deq_val), .deq_rdy(deq_rdy),
    .deq_data(deq_data), .credits(credits), .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: records issue/dequeue events, then plays the delay line (issue -> pipe_val next cycle).
  task automatic step();
    logic fi, fd, pv;
    logic [11:0] dd, rd;
    fi = req_val & req_rdy & reset_n;
    fd = deq_val & deq_rdy & reset_n;
    pv = pipe_val & reset_n;
    dd = deq_data;
    rd = req_data;
    @(posedge clk);
    #1;
    cyc++;
    if (fd) begin
      log_q.push_back(dd);
      logc_q.push_back(cyc);
    end
    if (fi) begin
      iss_q.push_back(rd);
      n_issued++;
      req_data = rd + 12'd1;
    end
    occ = reset_n ? occ + int'(pv) - int'(fd) : 0;
    pipe_val  = fi;
    pipe_data = fi ? rd : 12'h000;
  endtask

  task automatic clear_logs();
    iss_q.delete();
    log_q.delete();
    logc_q.delete();
    n_issued = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; req_val = 1'b0; deq_rdy = 1'b0;
    pipe_val = 1'b0; pipe_data = 12'h000; req_data = 12'h000;

    // Reset then idle
    step(); step();
    chk("rst_credits", credits, 3);
    chk("rst_req_rdy", req_rdy, 1);
    chk("rst_deq_val", deq_val, 0);
    chk("rst_overflow", overflow, 0);
    reset_n = 1'b1;
    clear_logs();

    // Streaming at full rate
    req_data = 12'h001; req_val = 1'b1; deq_rdy = 1'b1;
    step();
    chk("stream_lat0_deq_val", deq_val, 0);
    step();
    chk("stream_lat1_deq_val", deq_val, 1);
    chk("stream_lat1_deq_data", deq_data, 12'h001);
    for (int i = 0; i < 20; i++) begin
      req_val = (n_issued < 16);
      step();
      chk("stream_credits_nz", credits != 2'd0, 1);
    end
    chk("stream_count", log_q.size(), 16);
    for (int i = 0; i < 16; i++) begin
      chk("stream_data", (i < log_q.size()) ? log_q[i] : 12'hxxx, i + 1);
      if (i > 0 && i < logc_q.size())
        chk("stream_rate", logc_q[i] - logc_q[i-1], 1);
    end
    clear_logs();

    // Back-pressure
    deq_rdy = 1'b0; req_val = 1'b1; req_data = 12'h101;
    repeat (6) step();
    chk("bp_issues", n_issued, 3);
    chk("bp_req_rdy", req_rdy, 0);
    chk("bp_credits", credits, 0);
    chk("bp_deq_val", deq_val, 1);
    chk("bp_head_held", deq_data, 12'h101);
    chk("bp_overflow", overflow, 0);
    req_val = 1'b0; deq_rdy = 1'b1;
    step();
    chk("bp_rdy_reassert", req_rdy, 1);
    chk("bp_credits_1", credits, 1);
    repeat (3) step();
    chk("bp_drain_count", log_q.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("bp_drain_data", (i < log_q.size()) ? log_q[i] : 12'hxxx, 12'h101 + i);
    chk("bp_empty", deq_val, 0);
    chk("bp_credits_full", credits, 3);
    clear_logs();

    // Overflow injection
    deq_rdy = 1'b0; req_val = 1'b1; req_data = 12'h201;
    repeat (5) step();
    req_val = 1'b0;
    pipe_val = 1'b1; pipe_data = 12'hABC;
    step();
    chk("ovf_set", overflow, 1);
    chk("ovf_head", deq_data, 12'h201);
    step();
    chk("ovf_sticky", overflow, 1);
    deq_rdy = 1'b1;
    repeat (3) step();
    chk("ovf_drain_count", log_q.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("ovf_drain_data", (i < log_q.size()) ? log_q[i] : 12'hxxx, 12'h201 + i);
    chk("ovf_dropped", deq_val, 0);
    chk("ovf_still_sticky", overflow, 1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("ovf_cleared", overflow, 0);
    clear_logs();

    // Mid-operation reset with two words queued
    deq_rdy = 1'b0; req_val = 1'b1; req_data = 12'h301;
    step(); step();
    req_val = 1'b0;
    step();
    chk("mid_queued_val", deq_val, 1);
    chk("mid_queued_credits", credits, 1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("mid_rst_deq_val", deq_val, 0);
    chk("mid_rst_credits", credits, 3);
    chk("mid_rst_req_rdy", req_rdy, 1);
    step();
    chk("mid_rst_no_stale", deq_val, 0);
    clear_logs();

    // Same-cycle pipe -> deq path exists only with the bypass build
    pipe_val = 1'b1; pipe_data = 12'h5A5;
    #1;
`ifdef VC_LATENCY_SINK_BYPASS_EN
    chk("byp_deq_val", deq_val, 1);
    chk("byp_deq_data", deq_data, 12'h5A5);
`else
    chk("nobyp_deq_val", deq_val, 0);
`endif
    pipe_val = 1'b0; pipe_data = 12'h000;
    #1;

    // Random back-pressure with scoreboard and credit conservation
    occ = 0;
    req_val = 1'b1;
    for (int c = 0; c < 6000 && n_issued < 1000; c++) begin
      deq_rdy  = 1'($urandom_range(0, 1));
      req_data = 12'($urandom_range(0, 4095));
      step();
      while (log_q.size() > 0)
        chk("rand_order", log_q.pop_front(), (iss_q.size() > 0) ? iss_q.pop_front() : 12'hxxx);
      chk("rand_conserve", int'(credits) + occ + int'(pipe_val), 3);
      chk("rand_occ_le3", occ <= 3, 1);
      chk("rand_deq_val", deq_val, (occ != 0) || (BYP && pipe_val));
    end
    chk("rand_issued", n_issued, 1000);
    req_val = 1'b0; deq_rdy = 1'b1;
    repeat (5) begin
      step();
      while (log_q.size() > 0)
        chk("rand_order", log_q.pop_front(), (iss_q.size() > 0) ? iss_q.pop_front() : 12'hxxx);
    end
    chk("rand_all_drained", iss_q.size(), 0);
    chk("rand_final_credits", credits, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
